// File: rtl/banco_registradores_param_pkg.sv
// Shared definitions for the parametrised register bank.
//   - Default geometry (data/address width, port counts)
//   - Stack pointer defaults (step, reset value, floor, ceiling, bank slots)
//   - Stack operation decode type used by stack_ptr_unit
package banco_registradores_param_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_N_RD     = 2;
  localparam int unsigned DEF_N_STK    = 2;
  localparam int unsigned DEF_STK_STEP = 4;
  localparam int unsigned DEF_JR_IDX   = 29;

  localparam logic [31:0] DEF_STK_INIT = 32'h0000_0400;
  localparam logic [31:0] DEF_STK_LO   = 32'h0000_0000;
  localparam logic [31:0] DEF_STK_HI   = 32'h0000_0400;

  // Stack k pointer slot lives at [k*ADDR_W +: ADDR_W]: stack 0 -> 30, stack 1 -> 31.
  localparam logic [9:0]  DEF_STK_IDX  = {5'd31, 5'd30};

  typedef enum logic [1:0] {
    STK_IDLE = 2'b00,
    STK_PUSH = 2'b01,
    STK_POP  = 2'b10
  } stk_op_e;

endpackage

// File: rtl/banco_registradores_param_stk.sv
// stack_ptr_unit: next-pointer computation for one hardware stack.
//   push, pop  : requests (both together cancel out)
//   ptr        : current pointer value from the bank
//   nxt_ptr    : value the bank slot takes this edge (current value if refused)
//   we         : stack owns its bank slot this edge
//   ovf / unf  : refused push (below floor / wrap) / refused pop (above ceiling)
module stack_ptr_unit
  import banco_registradores_param_pkg::*;
#(
  parameter int unsigned        DATA_W   = DEF_DATA_W,
  parameter int unsigned        STK_STEP = DEF_STK_STEP,
  parameter logic [DATA_W-1:0]  STK_LO   = DEF_STK_LO,
  parameter logic [DATA_W-1:0]  STK_HI   = DEF_STK_HI
) (
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] ptr,
  output logic [DATA_W-1:0] nxt_ptr,
  output logic              we,
  output logic              ovf,
  output logic              unf
);

  localparam logic [DATA_W:0] STEP_W = (DATA_W+1)'(STK_STEP);

  stk_op_e         op;
  logic [DATA_W:0] dec;
  logic [DATA_W:0] inc;
  logic [DATA_W:0] floor_lim;

  assign dec       = {1'b0, ptr} - STEP_W;
  assign inc       = {1'b0, ptr} + STEP_W;
  // ptr - STEP < LO (including wrap below 0) is equivalent to ptr < LO + STEP
  // when evaluated one bit wider than the data path.
  assign floor_lim = {1'b0, STK_LO} + STEP_W;

  always_comb begin
    op = STK_IDLE;
    if (push && !pop)      op = STK_PUSH;
    else if (pop && !push) op = STK_POP;
  end

  always_comb begin
    nxt_ptr = ptr;
    we      = 1'b0;
    ovf     = 1'b0;
    unf     = 1'b0;
    case (op)
      STK_PUSH: begin
        we = 1'b1;
        if ({1'b0, ptr} < floor_lim) ovf = 1'b1;
        else                         nxt_ptr = dec[DATA_W-1:0];
      end
      STK_POP: begin
        we = 1'b1;
        if (inc > {1'b0, STK_HI}) unf = 1'b1;
        else                      nxt_ptr = inc[DATA_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/banco_registradores_param.sv
// banco_registradores_param: register bank for decode/writeback.
//   rd_en/rd_addr/rd_data : N_RD registered read ports, write-first bypass
//   wr0_* / wr1_*         : two write ports (wr1 wins on the same address)
//   hilo_we/hi_in/lo_in   : HI/LO pair load; hi_out/lo_out register outputs
//   stk_push/stk_pop      : per-stack requests; pointer held in bank slot STK_IDX[k]
//   stk_ptr               : registered pointer after this edge's update
//   stk_ovf/stk_unf       : sticky refused-push / refused-pop flags
//   jr_out                : combinational view of bank[JR_IDX]
module banco_registradores_param
  import banco_registradores_param_pkg::*;
#(
  parameter int unsigned               DATA_W   = DEF_DATA_W,
  parameter int unsigned               ADDR_W   = DEF_ADDR_W,
  parameter int unsigned               N_RD     = DEF_N_RD,
  parameter int unsigned               N_STK    = DEF_N_STK,
  parameter logic [N_STK*ADDR_W-1:0]   STK_IDX  = DEF_STK_IDX,
  parameter int unsigned               STK_STEP = DEF_STK_STEP,
  parameter logic [DATA_W-1:0]         STK_INIT = DEF_STK_INIT,
  parameter logic [DATA_W-1:0]         STK_LO   = DEF_STK_LO,
  parameter logic [DATA_W-1:0]         STK_HI   = DEF_STK_HI,
  parameter int unsigned               JR_IDX   = DEF_JR_IDX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     hilo_we,
  input  logic [DATA_W-1:0]        hi_in,
  input  logic [DATA_W-1:0]        lo_in,
  output logic [DATA_W-1:0]        hi_out,
  output logic [DATA_W-1:0]        lo_out,
  input  logic [N_STK-1:0]         stk_push,
  input  logic [N_STK-1:0]         stk_pop,
  output logic [N_STK*DATA_W-1:0]  stk_ptr,
  output logic [N_STK-1:0]         stk_ovf,
  output logic [N_STK-1:0]         stk_unf,
  output logic [DATA_W-1:0]        jr_out
);

  localparam int unsigned       NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] JR_A = ADDR_W'(JR_IDX);

  logic [DATA_W-1:0] bank     [NREG];
  logic [DATA_W-1:0] bank_nxt [NREG];
  logic [DATA_W-1:0] stk_cur  [N_STK];
  logic [DATA_W-1:0] stk_nxt  [N_STK];
  logic [N_STK-1:0]  stk_we;
  logic [N_STK-1:0]  ovf_set;
  logic [N_STK-1:0]  unf_set;

  for (genvar k = 0; k < N_STK; k++) begin : g_stk
    assign stk_cur[k] = bank[STK_IDX[k*ADDR_W +: ADDR_W]];

    stack_ptr_unit #(
      .DATA_W   (DATA_W),
      .STK_STEP (STK_STEP),
      .STK_LO   (STK_LO),
      .STK_HI   (STK_HI)
    ) u_stk (
      .push    (stk_push[k]),
      .pop     (stk_pop[k]),
      .ptr     (stk_cur[k]),
      .nxt_ptr (stk_nxt[k]),
      .we      (stk_we[k]),
      .ovf     (ovf_set[k]),
      .unf     (unf_set[k])
    );
  end

  // Post-edge image of the bank. Later assignments win, which encodes the
  // priority stack > wr1 > wr0; a refused stack op still owns its slot and
  // rewrites the current pointer, blocking any same-edge port write.
  always_comb begin
    bank_nxt = bank;
    if (wr0_en) bank_nxt[wr0_addr] = wr0_data;
    if (wr1_en) bank_nxt[wr1_addr] = wr1_data;
    for (int unsigned k = 0; k < N_STK; k++) begin
      if (stk_we[k]) bank_nxt[STK_IDX[k*ADDR_W +: ADDR_W]] = stk_nxt[k];
    end
    bank_nxt[0] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) bank[i] <= '0;
      for (int unsigned k = 0; k < N_STK; k++) bank[STK_IDX[k*ADDR_W +: ADDR_W]] <= STK_INIT;
    end else begin
      bank <= bank_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_STK; k++) stk_ptr[k*DATA_W +: DATA_W] <= STK_INIT;
      stk_ovf <= '0;
      stk_unf <= '0;
    end else begin
      for (int unsigned k = 0; k < N_STK; k++)
        stk_ptr[k*DATA_W +: DATA_W] <= bank_nxt[STK_IDX[k*ADDR_W +: ADDR_W]];
      stk_ovf <= stk_ovf | ovf_set;
      stk_unf <= stk_unf | unf_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (hilo_we) begin
      hi_out <= hi_in;
      lo_out <= lo_in;
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_rd
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        rd_data[p*DATA_W +: DATA_W] <= '0;
      else if (rd_en[p])
        rd_data[p*DATA_W +: DATA_W] <= bank_nxt[rd_addr[p*ADDR_W +: ADDR_W]];
    end
  end

  assign jr_out = bank[JR_A];

endmodule

// File: tb/tb_banco_registradores_param.sv
module tb_banco_registradores_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr0_en, wr1_en, hilo_we;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [31:0] wr0_data, wr1_data, hi_in, lo_in;
  logic [1:0]  stk_push, stk_pop;

  logic [63:0] rd_data, rd_data_b;
  logic [31:0] hi_out, lo_out, jr_out, hi_out_b, lo_out_b, jr_out_b;
  logic [63:0] stk_ptr, stk_ptr_b;
  logic [1:0]  stk_ovf, stk_unf, stk_ovf_b, stk_unf_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  banco_registradores_param u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_ptr(stk_ptr),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf), .jr_out(jr_out)
  );

  banco_registradores_param #(.STK_LO(32'h0000_03FC)) u_dut_lo (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out_b), .lo_out(lo_out_b),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_ptr(stk_ptr_b),
    .stk_ovf(stk_ovf_b), .stk_unf(stk_unf_b), .jr_out(jr_out_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr0_en = 0; wr1_en = 0; hilo_we = 0;
    stk_push = '0; stk_pop = '0;
  endtask

  initial begin
    rst = 1; rd_addr = '0; wr0_addr = '0; wr1_addr = '0;
    wr0_data = '0; wr1_data = '0; hi_in = '0; lo_in = '0;
    idle();
    tick(); tick();
    rst = 0;

    // Some activity, then a reset pulse in the middle of a write + push
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234;
    stk_push = 2'b01;
    hilo_we = 1; hi_in = 32'h55; lo_in = 32'h66;
    tick();
    chk("pre_rst_ptr0", stk_ptr[31:0], 64'h3FC);
    wr0_data = 32'hFFFF; rd_en = 2'b11; rd_addr = {5'd29, 5'd5};
    rst = 1;
    tick();
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_stk_ptr", stk_ptr, {32'h400, 32'h400});
    chk("rst_flags", {stk_ovf, stk_unf}, 64'h0);
    chk("rst_hilo", {hi_out, lo_out}, 64'h0);
    chk("rst_jr", jr_out, 64'h0);
    rst = 0; idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    chk("rst_bank5", rd_data[31:0], 64'h0);

    // Write-first bypass on the same edge
    idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    chk("bypass_rd0", rd_data[31:0], 64'hDEAD_BEEF);
    idle(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11;
    tick();
    chk("rd_hold", rd_data[31:0], 64'hDEAD_BEEF);
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    tick();
    chk("rd_after_write", rd_data[31:0], 64'h11);

    // wr1 beats wr0 on the same address; address 0 ignored
    idle(); wr0_en = 1; wr0_addr = 7; wr0_data = 32'h1;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h2;
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    tick();
    chk("wr_prio", rd_data[63:32], 64'h2);
    idle(); wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'hA5A5;
    rd_en = 2'b11; rd_addr = {5'd0, 5'd7};
    tick();
    chk("addr0_rd1", rd_data[63:32], 64'h0);
    chk("rd7_again", rd_data[31:0], 64'h2);

    // Stack 0: push, push, push+pop, pops, refused pop
    idle(); stk_push = 2'b01;
    tick();
    chk("push1", stk_ptr[31:0], 64'h3FC);
    tick();
    chk("push2", stk_ptr[31:0], 64'h3F8);
    chk("stk1_idle", stk_ptr[63:32], 64'h400);
    stk_pop = 2'b01;
    tick();
    chk("pushpop_nop", stk_ptr[31:0], 64'h3F8);
    chk("pushpop_flags", {stk_ovf, stk_unf}, 64'h0);
    idle(); stk_pop = 2'b01;
    tick(); tick();
    chk("pop_back", stk_ptr[31:0], 64'h400);
    chk("pop_noflag", stk_unf, 64'h0);
    tick();
    chk("pop_ceil_ptr", stk_ptr[31:0], 64'h400);
    chk("pop_ceil_unf", stk_unf, 64'h1);
    idle();
    tick();
    chk("unf_sticky", stk_unf, 64'h1);

    // Floor on the STK_LO = 0x3FC instance
    rst = 1; tick(); rst = 0;
    chk("rst_clears_unf", stk_unf, 64'h0);
    idle(); stk_push = 2'b01;
    tick();
    chk("lo_push1", stk_ptr_b[31:0], 64'h3FC);
    tick();
    chk("lo_push2_ptr", stk_ptr_b[31:0], 64'h3FC);
    chk("lo_ovf", stk_ovf_b, 64'h1);
    chk("dflt_push2_ptr", stk_ptr[31:0], 64'h3F8);
    chk("dflt_no_ovf", stk_ovf, 64'h0);
    idle(); stk_push = 2'b10;
    tick();
    chk("stk1_push", stk_ptr[63:32], 64'h3FC);

    // HI/LO load and jr_out
    idle(); hilo_we = 1; hi_in = 32'h1; lo_in = 32'h2;
    tick();
    chk("hilo", {hi_out, lo_out}, {32'h1, 32'h2});
    idle(); hi_in = 32'h9; lo_in = 32'h9;
    tick();
    chk("hilo_hold", {hi_out, lo_out}, {32'h1, 32'h2});
    wr0_en = 1; wr0_addr = 29; wr0_data = 32'h80;
    #1;
    chk("jr_before_edge", jr_out, 64'h0);
    tick();
    chk("jr_out", jr_out, 64'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
